// File: rtl/swap_pkg.sv
// Shared encodings for the register-swap scheduler and its arbiter.
package swap_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_NOP  = 3'd4
  } state_t;

  localparam logic WR_SRC_RD  = 1'b0;
  localparam logic WR_SRC_TMP = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  logic [$clog2(N)-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = $clog2(N)'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (valid_o) gnt_o = N'(1) << idx_o;
  end

endmodule

// File: rtl/swap_scheduler.sv
// Round-robin scheduler sequencing tmp<-R[a], R[a]<-R[b], R[b]<-tmp on a shared datapath.
module swap_scheduler
  import swap_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  addr_a,
  input  logic [N_REQ*ADDR_W-1:0]  addr_b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     tmp_we,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_src
);

  localparam int unsigned IW = $clog2(N_REQ);

  state_t              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d, ptr_q, ptr_d;
  logic [ADDR_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ADDR_W-1:0]   sel_a, sel_b;

  logic [N_REQ-1:0]    arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;

  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                tmp_we_q, tmp_we_d, wr_en_q, wr_en_d, wr_src_q, wr_src_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (IW'(k) == arb_idx) begin
        sel_a = addr_a[k*ADDR_W +: ADDR_W];
        sel_b = addr_b[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_idx;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = (sel_a == sel_b) ? S_NOP : S_T1;
          ptr_d   = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_IDLE;
      S_NOP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are the Moore decode of the next state, registered so they line up with state_q.
  always_comb begin
    gnt_d     = '0;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_T3) || (state_d == S_NOP);
    rd_addr_d = '0;
    tmp_we_d  = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_src_d  = WR_SRC_RD;
    if (state_d != S_IDLE) gnt_d = (state_q == S_IDLE) ? arb_gnt : gnt_q;
    case (state_d)
      S_T1: begin
        rd_addr_d = a_d;
        tmp_we_d  = 1'b1;
      end
      S_T2: begin
        rd_addr_d = b_d;
        wr_en_d   = 1'b1;
        wr_addr_d = a_d;
      end
      S_T3: begin
        wr_en_d   = 1'b1;
        wr_addr_d = b_d;
        wr_src_d  = WR_SRC_TMP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      tmp_we_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_src_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      tmp_we_q  <= tmp_we_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_src_q  <= wr_src_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_addr = rd_addr_q;
  assign tmp_we  = tmp_we_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_src  = wr_src_q;

endmodule

// File: tb/tb_swap_scheduler.sv
// Bench for swap_scheduler: vector table plus hand sequences, per-cycle expected outputs via a queue.
module tb_swap_scheduler;

  localparam int N  = 4;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr_a, addr_b;
  logic [N-1:0]    gnt;
  logic            busy, done, tmp_we, wr_en, wr_src;
  logic [AW-1:0]   rd_addr, wr_addr;

  always #5 clk = ~clk;

  swap_scheduler #(.N_REQ(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .addr_a(addr_a), .addr_b(addr_b),
    .gnt(gnt), .busy(busy), .done(done), .rd_addr(rd_addr), .tmp_we(tmp_we),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_src(wr_src)
  );

  // Datapath beside the scheduler: combinational read, writes on the closing edge.
  logic [7:0] rf [8];
  logic [7:0] tmp_r;
  logic       init_rf;
  always @(posedge clk) begin
    if (init_rf) begin
      for (int k = 0; k < 8; k++) rf[k] <= 8'(k * 17);
      rf[2] <= 8'hAA;
      rf[5] <= 8'h55;
    end else begin
      if (tmp_we) tmp_r <= rf[rd_addr];
      if (wr_en) rf[wr_addr] <= wr_src ? tmp_r : rf[rd_addr];
    end
  end

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic          tmp_we;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_src;
  } outs_t;

  typedef struct {
    logic [N-1:0]    req;
    logic [N*AW-1:0] aa;
    logic [N*AW-1:0] bb;
    int              owner;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    opn    = 0;
  outs_t exp_q[$];
  string name_q[$];
  vec_t  vt[7];
  logic [7:0] saved5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic outs_t mk(input int kind, input int owner, input logic [AW-1:0] a,
                               input logic [AW-1:0] b);
    outs_t o;
    o = '0;
    if (kind != 0) begin
      o.gnt  = N'(1 << owner);
      o.busy = 1'b1;
    end
    case (kind)
      1: begin o.rd_addr = a; o.tmp_we = 1'b1; end
      2: begin o.rd_addr = b; o.wr_en = 1'b1; o.wr_addr = a; end
      3: begin o.wr_en = 1'b1; o.wr_addr = b; o.wr_src = 1'b1; o.done = 1'b1; end
      4: o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [AW-1:0] field(input logic [N*AW-1:0] v, input int idx);
    return v[idx*AW +: AW];
  endfunction

  task automatic push(input int kind, input int owner, input logic [AW-1:0] a,
                      input logic [AW-1:0] b);
    exp_q.push_back(mk(kind, owner, a, b));
    name_q.push_back($sformatf("op%0d_own%0d_st%0d", opn, owner, kind));
  endtask

  // Queue one complete operation followed by its mandatory IDLE cycle.
  task automatic expect_op(input int owner, input logic [AW-1:0] a, input logic [AW-1:0] b);
    opn++;
    if (a == b) push(4, owner, a, b);
    else begin
      push(1, owner, a, b);
      push(2, owner, a, b);
      push(3, owner, a, b);
    end
    push(0, owner, a, b);
  endtask

  // Compare one queued record per cycle; withdraw req and scramble addresses at pop drop_at.
  task automatic drain(input int drop_at);
    outs_t act, expv;
    string nm;
    int    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      expv = exp_q.pop_front();
      nm   = name_q.pop_front();
      act  = {gnt, busy, done, rd_addr, tmp_we, wr_en, wr_addr, wr_src};
      chk(nm, 32'(act), 32'(expv));
      chk({nm, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
      if (n == drop_at) begin
        req    = '0;
        addr_a = ~addr_a;
        addr_b = ~addr_b;
      end
      n++;
    end
  endtask

  initial begin
    vt[0] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, {3'd0, 3'd0, 3'd0, 3'd5}, 0};
    vt[1] = '{4'b0100, {3'd1, 3'd3, 3'd6, 3'd2}, {3'd4, 3'd3, 3'd0, 3'd5}, 2};
    vt[2] = '{4'b0101, {3'd0, 3'd4, 3'd0, 3'd1}, {3'd0, 3'd7, 3'd0, 3'd6}, 0};
    vt[3] = '{4'b0101, {3'd0, 3'd4, 3'd0, 3'd1}, {3'd0, 3'd7, 3'd0, 3'd6}, 2};
    vt[4] = '{4'b1000, {3'd0, 3'd5, 3'd5, 3'd5}, {3'd7, 3'd5, 3'd5, 3'd5}, 3};
    vt[5] = '{4'b1110, {3'd2, 3'd2, 3'd6, 3'd0}, {3'd3, 3'd3, 3'd1, 3'd0}, 1};
    vt[6] = '{4'b0001, {3'd7, 3'd7, 3'd7, 3'd0}, {3'd6, 3'd6, 3'd6, 3'd0}, 0};

    init_rf = 1'b1;
    reset   = 1'b1;
    req     = '0;
    addr_a  = '0;
    addr_b  = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({gnt, busy, done, rd_addr, tmp_we, wr_en, wr_addr, wr_src}),
        32'(mk(0, 0, 3'd0, 3'd0)));
    init_rf = 1'b0;
    reset   = 1'b0;
    @(negedge clk);

    // Table: single swap, NOP, wrap-and-skip, plain grants; req dropped during the first op cycle.
    for (int i = 0; i < 7; i++) begin
      req    = vt[i].req;
      addr_a = vt[i].aa;
      addr_b = vt[i].bb;
      expect_op(vt[i].owner, field(vt[i].aa, vt[i].owner), field(vt[i].bb, vt[i].owner));
      drain(0);
    end
    push(0, 0, 3'd0, 3'd0);
    push(0, 0, 3'd0, 3'd0);
    drain(-1);
    chk("rf2_swapped", 32'(rf[2]), 32'h55);
    chk("rf5_swapped", 32'(rf[5]), 32'hAA);
    chk("rf3_nop_unchanged", 32'(rf[3]), 32'h33);

    // Reset during T2: no T3 write, no done, pointer back to 0.
    saved5 = rf[5];
    req    = 4'b0010;
    addr_a = {3'd0, 3'd0, 3'd2, 3'd0};
    addr_b = {3'd0, 3'd0, 3'd5, 3'd0};
    opn++;
    push(1, 1, 3'd2, 3'd5);
    push(2, 1, 3'd2, 3'd5);
    drain(0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_T2", 32'({gnt, busy, done, rd_addr, tmp_we, wr_en, wr_addr, wr_src}),
        32'(mk(0, 0, 3'd0, 3'd0)));
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_T2_idle", 32'({gnt, busy, done}), 32'd0);
    chk("rf5_no_T3_write", 32'(rf[5]), 32'(saved5));
    chk("rf2_T2_write", 32'(rf[2]), 32'(saved5));

    // Contention: all requesting; order 0,1,2,3,0 and done every 4 cycles.
    req    = '1;
    addr_a = {3'd3, 3'd2, 3'd1, 3'd0};
    addr_b = {3'd7, 3'd6, 3'd5, 3'd4};
    for (int i = 0; i < 4; i++) expect_op(i, 3'(i), 3'(i + 4));
    expect_op(0, 3'd0, 3'd4);
    drain(16);
    push(0, 0, 3'd0, 3'd0);
    push(0, 0, 3'd0, 3'd0);
    drain(-1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swap_scheduler.md
# swap_scheduler

Arbitrating controller for the shared register-swap datapath: a register file with one combinational read port, one write port and a single temp register. Up to N_REQ requesters each present a pair of register addresses. The block grants one requester at a time in round-robin order and sequences the three-step exchange tmp←R[a], R[a]←R[b], R[b]←tmp. It drives only control signals; the register file and temp register live in the datapath beside it.

## Interface
- N_REQ, 4, number of requesters (≥2)
- ADDR_W, 3, register-file address width
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester swap request, level
- addr_a  input  N_REQ*ADDR_W  first address, requester i at bits [i*ADDR_W +: ADDR_W]
- addr_b  input  N_REQ*ADDR_W  second address, same packing
- gnt  output  N_REQ  one-hot, owner of the current operation
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, operation complete
- rd_addr  output  ADDR_W  register-file read address
- tmp_we  output  1  load temp register from read data
- wr_en  output  1  register-file write enable
- wr_addr  output  ADDR_W  register-file write address
- wr_src  output  1  write data source: 0 = read data, 1 = temp

## Operation
- States: IDLE, T1, T2, T3, NOP.
- Outputs are a Moore decode of the state register plus the latched owner and addresses.
- IDLE:
  - If req ≠ 0, the round-robin arbiter picks the winner: the first set bit at or after ptr, wrapping.
  - Latch winner index, a and b.
  - Go to NOP if a == b, else T1.
  - ptr ← winner+1 mod N_REQ.
- T1: rd_addr=a, tmp_we=1 → T2.
- T2: rd_addr=b, wr_en=1, wr_addr=a, wr_src=0 → T3.
- T3: wr_en=1, wr_addr=b, wr_src=1, done=1 → IDLE.
- NOP: no writes, tmp_we=0, done=1 → IDLE.
- gnt = one-hot of the latched owner in T1/T2/T3/NOP; 0 in IDLE.
- busy = state ≠ IDLE.
- Requests are sampled only in IDLE.
- Deasserting req or changing addresses mid-operation has no effect; the operation completes.
- A requester still asserting req after its done is a new request, subject to round-robin.
- Outputs not asserted in a state are 0, including rd_addr and wr_addr, to keep traces clean.

## Timing
- Reset: state=IDLE, ptr=0, latched owner/addresses=0, all outputs 0.
- Reset asserted mid-operation: IDLE on the next edge, no further writes, no done.
- Latency for a granted swap:
  - req seen in IDLE at edge n.
  - T1 during cycle n+1, T2 at n+2, T3 (done) at n+3.
  - IDLE at n+4.
- Same-address swap: done at n+1.
- Throughput: one swap per 4 cycles; one per 2 for NOP.
- IDLE always lasts at least one cycle between operations.
- Datapath contract: register-file read is combinational; tmp and register-file writes occur on the edge ending the cycle in which the enable is high.

## Structure
- Shared package `swap_pkg`:
  - state encoding (IDLE=0, T1=1, T2=2, T3=3, NOP=4; 3-bit)
  - WR_SRC_RD=0, WR_SRC_TMP=1
- Sub-module `rr_arbiter` (parameter N):
  - inputs req and ptr
  - outputs one-hot grant, grant index and valid
  - purely combinational
- The pointer register stays in swap_scheduler.

## Test plan
- Single swap, N_REQ=4: req=0001, a=2, b=5, R2=0xAA, R5=0x55.
  - T1: rd_addr=2, tmp_we=1.
  - T2: wr 2←read(5).
  - T3: wr 5←tmp, done.
  - Result: R2=0x55, R5=0xAA.
  - gnt=0001 for 3 cycles.
- Contention: req=1111 held for 16 cycles.
  - Grants in order 0, 1, 2, 3, then 0 again.
  - done pulses 4 cycles apart.
  - gnt always one-hot.
- Same address: req=0100, a=b=3.
  - NOP for 1 cycle: done=1, wr_en=0, tmp_we=0.
  - R3 unchanged.
  - ptr moves to 3.
- Request withdrawn: req drops to 0 in T1.
  - T2 and T3 still execute and done fires.
  - No new grant afterwards.
- Reset in T2: reset=1 for one cycle.
  - Next cycle: IDLE, gnt=0, busy=0, no T3 write, no done.
  - ptr=0.
- Wrap and skip: ptr=3, req=0101.
  - Grant goes to 0, then 2.
